pulse_period_meter: RTL and testbench

Receive side of the periodic single-cycle tick used across the design. Synchronizes an incoming pulse train, measures the clk-cycle spacing between consecutive rising edges, and reports each measured period with a one-cycle valid strobe. Flags a missing-pulse timeout and a "locked" condition when the spacing is stable. Sits between any tick source, on-chip or off-pin, and status/debug logic.

---
 rtl/pulse_pkg.sv | 15 +
 rtl/sync_rise_detect.sv | 28 ++
 rtl/pulse_period_meter.sv | 101 ++++++++++
 tb/tb_pulse_period_meter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the tick generator / period meter pair:
// the measurement FSM state encoding and the counter width helper.
package pulse_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  // Counter width able to hold values 0..max_val inclusive.
  function automatic int width_for(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Brings an external strobe into the clk domain through a flop chain
// and flags a one-cycle event on each synchronized rising edge.
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Shift the input through the synchronizer and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle spacing between rising edges of a pulse train,
// strobes each new period, and reports lock (stable spacing) and a
// sticky missing-pulse timeout.
module pulse_period_meter
  import pulse_pkg::*;
#(
  parameter int  TIMEOUT     = 1024,
  parameter int  SYNC_STAGES = 2,
  localparam int W           = width_for(TIMEOUT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pulse_in,
  output logic [W-1:0] period_out,
  output logic         period_valid,
  output logic         locked,
  output logic         timeout
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = W'(1);
  localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT);

  logic         ev_s;
  state_e       state_q;
  logic [W-1:0] count_q;
  logic [W-1:0] period_q;
  logic [W-1:0] prev_q;
  logic         have_prev_q;
  logic         valid_q;
  logic         locked_q;
  logic         timeout_q;

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pulse_in),
    .rise  (ev_s)
  );

  // Measurement FSM: arm on the first edge, report each later spacing,
  // and fall back to IDLE when no edge arrives within TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= CNT_ZERO;
      period_q    <= CNT_ZERO;
      prev_q      <= CNT_ZERO;
      have_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ev_s) begin
            // First edge only arms; lock history starts fresh.
            state_q     <= MEASURE;
            count_q     <= CNT_ONE;
            timeout_q   <= 1'b0;
            have_prev_q <= 1'b0;
          end else begin
            count_q <= CNT_ZERO;
          end
        end
        MEASURE: begin
          if (ev_s) begin
            // An edge takes priority even when the count sits at TIMEOUT.
            period_q    <= count_q;
            valid_q     <= 1'b1;
            count_q     <= CNT_ONE;
            locked_q    <= have_prev_q && (count_q == prev_q);
            prev_q      <= count_q;
            have_prev_q <= 1'b1;
          end else if (count_q < CNT_MAX) begin
            count_q <= count_q + CNT_ONE;
          end else begin
            state_q   <= IDLE;
            count_q   <= CNT_ZERO;
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          count_q  <= CNT_ZERO;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter with TIMEOUT=16, SYNC_STAGES=2.
module tb_pulse_period_meter;
  import pulse_pkg::*;

  localparam int TMO = 16;
  localparam int WW  = width_for(TMO);

  logic          clk;
  logic          rst_n;
  logic          pulse_in;
  logic [WW-1:0] period_out;
  logic          period_valid;
  logic          locked;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  pulse_period_meter #(
    .TIMEOUT     (TMO),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_in     (pulse_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input int ev, input int ep, input int el, input int et);
    chk({tag, ".valid"},   32'(period_valid), 32'(ev));
    chk({tag, ".period"},  32'(period_out),   32'(ep));
    chk({tag, ".locked"},  32'(locked),       32'(el));
    chk({tag, ".timeout"}, 32'(timeout),      32'(et));
  endtask

  // One-cycle pulse sampled at edge E0; strobe expected after E0+2.
  // Consumes exactly gap edges (gap >= 4) before the next pulse.
  task automatic pulse_check(input string tag, input int gap, input int ev,
                             input int ep, input int el, input int et);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    tick();
    chk({tag, ".early"}, 32'(period_valid), 32'd0);
    tick();
    chk_outs(tag, ev, ep, el, et);
    tick();
    chk({tag, ".one_cycle"}, 32'(period_valid), 32'd0);
    repeat (gap - 4) tick();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int strobes;
    rst_n    = 1'b0;
    pulse_in = 1'b0;

    // 1: reset clears everything
    do_reset(3);
    chk_outs("reset", 0, 0, 0, 0);
    tick();
    chk("reset.state", 32'(dut.state_q), 32'(IDLE));

    // 2: 5-cycle train, 4 pulses
    pulse_check("p5_1", 5, 0, 0, 0, 0);
    pulse_check("p5_2", 5, 1, 5, 0, 0);
    pulse_check("p5_3", 5, 1, 5, 1, 0);
    pulse_check("p5_4", 5, 1, 5, 1, 0);

    // 6: reset between pulses while locked
    do_reset(1);
    chk_outs("midrst", 0, 0, 0, 0);
    pulse_check("rst_arm", 5, 0, 0, 0, 0);
    pulse_check("rst_p2", 5, 1, 5, 0, 0);
    pulse_check("rst_p3", 5, 1, 5, 1, 0);

    // 4: locked train, then pulses stop -> timeout after 16 idle cycles
    pulse_check("tmo_last", 4, 1, 5, 1, 0);
    repeat (14) tick();
    chk_outs("tmo_before", 0, 5, 1, 0);
    tick();
    chk_outs("tmo_hit", 0, 5, 0, 1);
    tick();
    chk("tmo_sticky", 32'(timeout), 32'd1);
    // next pulse re-arms, clears timeout, no strobe
    pulse_check("tmo_rearm", 16, 0, 5, 0, 0);

    // 5: exactly TIMEOUT apart -> edge wins, period 16 reported
    pulse_check("edge16", 17, 1, 16, 0, 0);
    // 17 apart -> timeout raised before the edge, then re-armed, no strobe
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    tick();
    chk_outs("gap17_tmo", 0, 16, 0, 1);
    tick();
    chk_outs("gap17_rearm", 0, 16, 0, 0);

    // 3: pulses every 2 cycles
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      pulse_in = 1'b1;
      tick();
      chk("p2.valid",  32'(period_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        chk("p2.period", 32'(period_out), 32'd2);
        chk("p2.locked", 32'(locked), (k >= 3) ? 32'd1 : 32'd0);
      end
      pulse_in = 1'b0;
      tick();
      chk("p2.gapvalid", 32'(period_valid), 32'd0);
    end

    // constant-high input: one arm edge, no strobes, ends in timeout
    do_reset(1);
    pulse_in = 1'b1;
    strobes  = 0;
    repeat (24) begin
      tick();
      if (period_valid) strobes++;
    end
    chk("high.strobes", 32'(strobes), 32'd0);
    chk("high.timeout", 32'(timeout), 32'd1);
    pulse_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
